pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Parametrised pipeline controller for the in-order RV64 core. It owns the PC,
//  the instruction-fetch handshake and the per-register enable/flush vector.
//  It resolves memory stalls, load-use hazards and execute-stage redirects.
//  A fetch miss now injects a bubble instead of freezing the whole pipe.
//  Sits between ibus and the pipeline registers.
// PARAMETERS
//  NREG      4             pipeline registers; reg k sits after stage k (0=F/D .. 3=M/W)
//  EX_STAGE  2             stage that raises redirect (reads reg EX_STAGE-1)
//  MEM_STAGE 3             stage that issues dbus requests (reads reg MEM_STAGE-1)
//  PC_RESET  64'h8000_0000 PC after reset
//  CNT_W     32            width of performance counters
// PORTS
//  clk            in   1      clock
//  reset          in   1      reset, synchronous, active-high
//  ireq_valid     out  1      instruction request valid
//  ireq_addr      out  64     instruction request address
//  i_data_ok      in   1      ibus response valid
//  i_data         in   32     ibus response data
//  d_req_valid    in   1      memory stage has a dbus request outstanding
//  d_data_ok      in   1      dbus response valid
//  load_use       in   1      decode detected a load-use hazard
//  redirect_valid in   1      execute resolved a taken branch or jump
//  redirect_pc    in   64     redirect target
//  fetch_valid    out  1      instr/fetch_pc valid for loading into reg 0
//  instr          out  32     fetched instruction
//  fetch_pc       out  64     PC of instr
//  reg_en         out  NREG   reg k loads its next value
//  reg_flush      out  NREG   reg k loads a bubble (valid=0); overrides reg_en
//  stall_cnt      out  CNT_W  cycles with reg_en[0]==0, saturating
//  redirect_cnt   out  CNT_W  accepted redirects, saturating
// BEHAVIOUR
//  Reset values:
//   - pc=PC_RESET, FSM=REQ, ireq_valid=0 on the reset cycle.
//   - reg_en='0, reg_flush='1, counters=0, fetch_valid=0.
//  Stall sources, evaluated combinationally in priority order:
//   - mstall = d_req_valid & ~d_data_ok.
//     Effect: reg_en[0..MEM_STAGE-1]=0, reg_flush[MEM_STAGE]=1, later regs enabled.
//   - redir = redirect_valid & ~mstall.
//     Effect: reg_flush[0..EX_STAGE-1]=1, reg EX_STAGE and later enabled; redirect_cnt++.
//   - lu = load_use & ~mstall & ~redir.
//     Effect: reg_en[0]=0, reg_flush[1]=1, others enabled.
//   - While mstall is high the redirect is ignored; the source holds it until accepted.
//  Fetch FSM: states REQ, HOLD, DISCARD.
//   - REQ: ireq_valid=1, ireq_addr=pc. The address is stable until i_data_ok.
//     - i_data_ok and reg 0 can load: fetch_valid=1, pc<=pc+4 (mod 2^64).
//     - i_data_ok, reg 0 frozen: latch i_data/pc into the buffer, go to HOLD.
//     - No i_data_ok: reg_flush[0]=1 (bubble), unless reg 0 is frozen.
//     - redir with no i_data_ok: pend_pc<=redirect_pc, go to DISCARD.
//     - redir with i_data_ok: drop the data and set pc<=redirect_pc.
//   - HOLD: ireq_valid=0, buffered instr presented.
//     - On the first cycle reg 0 can load: fetch_valid=1, pc<=pc+4, go to REQ.
//     - redir in HOLD: drop the buffer, pc<=redirect_pc, go to REQ.
//   - DISCARD: ireq_valid=1 with the old address held.
//     - On i_data_ok: drop the data, pc<=pend_pc, go to REQ.
//     - A further redir overwrites pend_pc.
//  The redirect wins over an i_data_ok in the same cycle.
//  Latency: data_ok-to-reg0 is 0 cycles in REQ. Redirect-to-first-target-request is 1 cycle.
//  Reset mid-request: state is discarded; the bus sees ireq_valid drop.
// STRUCTURE
//  Shared pipes package:
//   - fetch_state_t enum.
//   - stall_vec_t = logic [NREG-1:0].
//   - PC_RESET default.
//  Sub-module: pipe_stall_vec (combinational priority encoder producing reg_en/reg_flush).
//  The FSM, PC, buffer and counters live in pipe_ctrl.
// TESTING
//  1. Reset, then i_data_ok every cycle:
//     ireq_addr=8000_0000, 8000_0004, 8000_0008; fetch_valid=1 each cycle.
//  2. d_req_valid=1, d_data_ok=0 for 3 cycles:
//     reg_en=4'b1000, reg_flush=4'b1000 each cycle, pc frozen, stall_cnt=3.
//  3. load_use for 1 cycle:
//     reg_en[0]=0, reg_flush[1]=1, pc unchanged, next cycle normal.
//  4. redirect to 8000_0100 while the fetch of 8000_0008 is outstanding:
//     DISCARD; the later i_data_ok data is dropped; next ireq_addr=8000_0100; redirect_cnt=1.
//  5. i_data_ok during mstall:
//     HOLD, ireq_valid=0; on release fetch_valid=1 with the buffered instr, then ireq_addr=pc+4.
//  6. redirect_valid and mstall together, then mstall drops:
//     redirect applied only after release; reg_flush[1:0]=2'b11.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: fetch FSM states,
// default geometry, reset PC and a small PC helper.
package pipe_ctrl_pkg;

  localparam int          DEF_NREG     = 4;
  localparam logic [63:0] DEF_PC_RESET = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  typedef logic [DEF_NREG-1:0] stall_vec_t;

  // Sequential fetch address; wraps modulo 2^64.
  function automatic logic [63:0] pc_next(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/pipe_stall_vec.sv
// Priority encoder turning the resolved stall sources into the per-register
// enable/flush vectors. Memory stall beats redirect beats load-use; with no
// stall, reg 0 takes a bubble whenever the fetch side has nothing to give.
module pipe_stall_vec #(
  parameter int NREG      = 4,
  parameter int EX_STAGE  = 2,
  parameter int MEM_STAGE = 3
) (
  input  logic            reset,
  input  logic            mstall,
  input  logic            redir,
  input  logic            lu,
  input  logic            fetch_bubble,
  output logic [NREG-1:0] reg_en,
  output logic [NREG-1:0] reg_flush
);

  // Select the enable/flush pattern of the highest-priority active source.
  always_comb begin
    reg_en    = '1;
    reg_flush = '0;
    if (reset) begin
      reg_en    = '0;
      reg_flush = '1;
    end else if (mstall) begin
      // Everything upstream of the memory stage freezes; the memory-stage
      // output register gets a bubble so later stages keep draining.
      for (int k = 0; k < NREG; k++) begin
        if (k < MEM_STAGE) begin
          reg_en[k] = 1'b0;
        end else if (k == MEM_STAGE) begin
          reg_flush[k] = 1'b1;
        end else begin
          reg_en[k] = 1'b1;
        end
      end
    end else if (redir) begin
      // Squash the wrong-path instructions younger than execute.
      for (int k = 0; k < NREG; k++) begin
        if (k < EX_STAGE) begin
          reg_flush[k] = 1'b1;
        end else begin
          reg_flush[k] = 1'b0;
        end
      end
    end else if (lu) begin
      // Hold the consumer in decode, insert a bubble behind it.
      for (int k = 0; k < NREG; k++) begin
        if (k == 0) begin
          reg_en[k] = 1'b0;
        end else if (k == 1) begin
          reg_flush[k] = 1'b1;
        end else begin
          reg_en[k] = 1'b1;
        end
      end
    end else begin
      reg_flush[0] = fetch_bubble;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: owns the PC, the ibus fetch handshake (with a
// one-entry hold buffer and a discard state for redirected in-flight
// fetches), and the stall/redirect performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          NREG      = DEF_NREG,
  parameter int          EX_STAGE  = 2,
  parameter int          MEM_STAGE = 3,
  parameter logic [63:0] PC_RESET  = DEF_PC_RESET,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ireq_valid,
  output logic [63:0]      ireq_addr,
  input  logic             i_data_ok,
  input  logic [31:0]      i_data,
  input  logic             d_req_valid,
  input  logic             d_data_ok,
  input  logic             load_use,
  input  logic             redirect_valid,
  input  logic [63:0]      redirect_pc,
  output logic             fetch_valid,
  output logic [31:0]      instr,
  output logic [63:0]      fetch_pc,
  output logic [NREG-1:0]  reg_en,
  output logic [NREG-1:0]  reg_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_t state;
  logic [63:0]  pc;
  logic [63:0]  pend_pc;
  logic [31:0]  hold_instr;

  logic mstall;
  logic redir;
  logic lu;
  logic reg0_ready;

  assign mstall     = d_req_valid & ~d_data_ok;
  assign redir      = redirect_valid & ~mstall;
  assign lu         = load_use & ~mstall & ~redir;
  assign reg0_ready = ~mstall & ~lu;

  // Fetch-side outputs; data reaches reg 0 in the same cycle it arrives.
  always_comb begin
    ireq_valid  = 1'b0;
    ireq_addr   = pc;
    fetch_valid = 1'b0;
    instr       = i_data;
    fetch_pc    = pc;
    case (state)
      ST_REQ: begin
        ireq_valid  = 1'b1;
        fetch_valid = i_data_ok & ~redir & reg0_ready;
      end
      ST_HOLD: begin
        instr       = hold_instr;
        fetch_valid = ~redir & reg0_ready;
      end
      ST_DISCARD: begin
        ireq_valid = 1'b1;
      end
      default: begin
        ireq_valid = 1'b0;
      end
    endcase
    if (reset) begin
      ireq_valid  = 1'b0;
      fetch_valid = 1'b0;
    end else begin
      ireq_valid  = ireq_valid;
      fetch_valid = fetch_valid;
    end
  end

  pipe_stall_vec #(
    .NREG      (NREG),
    .EX_STAGE  (EX_STAGE),
    .MEM_STAGE (MEM_STAGE)
  ) u_stall_vec (
    .reset        (reset),
    .mstall       (mstall),
    .redir        (redir),
    .lu           (lu),
    .fetch_bubble (~fetch_valid),
    .reg_en       (reg_en),
    .reg_flush    (reg_flush)
  );

  // Fetch FSM, PC, hold buffer and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_REQ;
      pc           <= PC_RESET;
      pend_pc      <= PC_RESET;
      hold_instr   <= 32'd0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!reg_en[0] && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (redir && (redirect_cnt != {CNT_W{1'b1}})) begin
        redirect_cnt <= redirect_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state)
        ST_REQ: begin
          if (redir) begin
            // The request address must not move while it is outstanding,
            // so an unanswered fetch is drained in DISCARD first.
            if (i_data_ok) begin
              pc <= redirect_pc;
            end else begin
              pend_pc <= redirect_pc;
              state   <= ST_DISCARD;
            end
          end else if (i_data_ok) begin
            if (reg0_ready) begin
              pc <= pc_next(pc);
            end else begin
              hold_instr <= i_data;
              state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (redir) begin
            pc    <= redirect_pc;
            state <= ST_REQ;
          end else if (reg0_ready) begin
            pc    <= pc_next(pc);
            state <= ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (i_data_ok) begin
            pc    <= redir ? redirect_pc : pend_pc;
            state <= ST_REQ;
          end else if (redir) begin
            pend_pc <= redirect_pc;
          end
        end
        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

endmodule
